sr_reg_bank: RTL and testbench
==============================

// Module: sr_reg_bank
// PURPOSE
//   Parametrised bank of WIDTH independent SR storage bits with a selectable S&R-conflict policy.
//   Generalises the single SR flip-flop and defines a deterministic result for S=R=1 (no X).
//   Adds per-channel edge pulses, sticky conflict flags and a saturating conflict counter.
//   Used as a status/flag register bank between event sources and control FSMs.
// PARAMETERS
//   WIDTH      8        number of SR channels (1..32)
//   MODE       0        S=R=1 policy: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle (JK)
//   RESET_VAL  0        WIDTH-bit value loaded into Q on reset
//   CNT_W      8        width of conflict_cnt (2..16)
// PORTS
//   clk           in   1       rising-edge clock
//   reset         in   1       synchronous, active-high reset
//   en            in   1       update enable; 0 = all channels hold
//   S             in   WIDTH   per-channel set request
//   R             in   WIDTH   per-channel reset request
//   clr_err       in   1       clears err_mask and conflict_cnt
//   Q             out  WIDTH   stored state (registered)
//   Qbar          out  WIDTH   ~Q (combinational)
//   rise          out  WIDTH   1-cycle pulse: bit went 0->1 on this edge (registered)
//   fall          out  WIDTH   1-cycle pulse: bit went 1->0 on this edge (registered)
//   err_mask      out  WIDTH   sticky: channel saw S=R=1 while en=1
//   err           out  1       |err_mask (combinational)
//   conflict_cnt  out  CNT_W   saturating count of cycles with any conflict
// BEHAVIOUR
//   - Reset (sampled at posedge clk while reset=1): Q=RESET_VAL, rise=fall=0, err_mask=0,
//     conflict_cnt=0. reset overrides en, S, R, clr_err. Qbar=~RESET_VAL, err=0 after that edge.
//   - Per channel i, en=1: {S,R}=00 hold; 01 -> 0; 10 -> 1; 11 -> MODE policy
//     (0 hold, 1 -> 1, 2 -> 0, 3 -> ~Q[i]). Q never takes X/Z.
//   - en=0: Q holds, rise=fall=0, no conflict recorded, S/R ignored; clr_err still acts.
//   - Latency: Q reflects S/R sampled at edge N after edge N (1 cycle).
//   - rise[i]/fall[i] are registered with Q: high for exactly the cycle after the edge on
//     which Q[i] changed, otherwise 0. A write that leaves Q unchanged produces no pulse.
//   - Conflict: channel i conflicts when en & S[i] & R[i] (every MODE, including hold).
//     err_mask[i] <= err_mask[i] | conflict[i]; with clr_err: err_mask[i] <= conflict[i].
//   - conflict_cnt: +1 on each cycle with |conflict; saturates at 2^CNT_W-1, never wraps.
//     clr_err alone -> 0; clr_err with a conflict in the same cycle -> 1.
//   - Many channels in conflict in one cycle still add exactly 1 to the count.
//   - Reset mid-sequence discards pending state; no pulse is generated on the reset edge.
// TESTING
//   1. WIDTH=4, RESET_VAL=4'b1010, hold reset -> Q=1010, Qbar=0101, rise=fall=0, err=0, cnt=0.
//   2. en=1, S=0001,R=0000 -> Q=1011, rise=0001 for 1 cycle; then R=0001 -> Q=1010, fall=0001.
//   3. MODE=3, S=R=0100 for 3 cycles -> Q[2] toggles 1,0,1 per cycle; err_mask=0100,
//      cnt=3; with MODE=0 same stimulus -> Q unchanged, cnt=3.
//   4. CNT_W=2, S=R=1111 for 5 cycles -> cnt 1,2,3,3,3; then clr_err with S=R=0001
//      -> err_mask=0001, cnt=1.
//   5. en=0, S=1111,R=1111, clr_err=1 -> Q holds, no pulses, err_mask=0, cnt=0.
//   6. Q=1111, apply reset with S=1111 -> Q=RESET_VAL next cycle, fall=0, rise=0.

Source files
------------

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH independent SR storage bits with a selectable S=R=1 policy,
// per-channel edge pulses, sticky conflict flags and a saturating conflict counter.
module sr_reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      MODE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] err_mask,
  output logic             err,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_err_mask;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_conflict;
  logic             w_any_conflict;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin
    w_q_next = r_q;
    if (en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        case ({S[i], R[i]})
          2'b01:   w_q_next[i] = 1'b0;
          2'b10:   w_q_next[i] = 1'b1;
          2'b11: begin
            case (MODE)
              1:       w_q_next[i] = 1'b1;
              2:       w_q_next[i] = 1'b0;
              3:       w_q_next[i] = ~r_q[i];
              default: w_q_next[i] = r_q[i];
            endcase
          end
          default: w_q_next[i] = r_q[i];
        endcase
      end
    end
  end

  assign w_conflict     = en ? (S & R) : '0;
  assign w_any_conflict = |w_conflict;

  // A clear in the same cycle as a conflict restarts the count at 1, not 0.
  always_comb begin
    w_cnt_next = r_cnt;
    if (clr_err) begin
      w_cnt_next = w_any_conflict ? CNT_W'(1) : '0;
    end else if (w_any_conflict && (r_cnt != '1)) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q        <= RESET_VAL;
      r_rise     <= '0;
      r_fall     <= '0;
      r_err_mask <= '0;
      r_cnt      <= '0;
    end else begin
      r_q        <= w_q_next;
      r_rise     <= w_q_next & ~r_q;
      r_fall     <= r_q & ~w_q_next;
      r_err_mask <= clr_err ? w_conflict : (r_err_mask | w_conflict);
      r_cnt      <= w_cnt_next;
    end
  end

  assign Q            = r_q;
  assign Qbar         = ~r_q;
  assign rise         = r_rise;
  assign fall         = r_fall;
  assign err_mask     = r_err_mask;
  assign err          = |r_err_mask;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Scoreboard bench: four instances (MODE 0..3) share randomized stimulus; a
// behavioural model pushes expected outputs, a monitor pops and compares.
module tb_sr_reg_bank;

  localparam logic [3:0] RV = 4'b1010;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_en = 1'b0;
  logic [3:0] i_s = '0;
  logic [3:0] i_r = '0;
  logic       i_clr = 1'b0;

  logic [3:0] w_q[4], w_qbar[4], w_rise[4], w_fall[4], w_errm[4];
  logic       w_err[4];
  logic [1:0] w_cnt[4];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_reg_bank #(.WIDTH(4), .MODE(m), .RESET_VAL(RV), .CNT_W(2)) u_dut (
      .clk(clk), .reset(i_reset), .en(i_en), .S(i_s), .R(i_r), .clr_err(i_clr),
      .Q(w_q[m]), .Qbar(w_qbar[m]), .rise(w_rise[m]), .fall(w_fall[m]),
      .err_mask(w_errm[m]), .err(w_err[m]), .conflict_cnt(w_cnt[m])
    );
  end

  typedef struct packed {
    logic [3:0][3:0] q;
    logic [3:0][3:0] qbar;
    logic [3:0][3:0] rise;
    logic [3:0][3:0] fall;
    logic [3:0][3:0] errm;
    logic [3:0]      err;
    logic [3:0][1:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference state per mode instance
  logic [3:0] mq[4];
  logic [3:0] mem[4];
  int         mc[4];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int m, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s mode%0d t=%0t: got %b expected %b", nm, m, $time, act, exp);
    end
  endtask

  task automatic apply(input bit rst, input bit en, input logic [3:0] s, input logic [3:0] r,
                       input bit clr);
    exp_t       e;
    logic [3:0] nq;
    logic [3:0] conf;
    @(negedge clk);
    i_reset = rst; i_en = en; i_s = s; i_r = r; i_clr = clr;
    e = '0;
    for (int m = 0; m < 4; m++) begin
      if (rst) begin
        nq = RV;
        e.rise[m] = '0;
        e.fall[m] = '0;
        mem[m] = '0;
        mc[m] = 0;
      end else begin
        nq = mq[m];
        conf = '0;
        if (en) begin
          for (int i = 0; i < 4; i++) begin
            if (s[i] && !r[i]) nq[i] = 1'b1;
            else if (r[i] && !s[i]) nq[i] = 1'b0;
            else if (s[i] && r[i]) begin
              conf[i] = 1'b1;
              if (m == 1) nq[i] = 1'b1;
              else if (m == 2) nq[i] = 1'b0;
              else if (m == 3) nq[i] = ~mq[m][i];
            end
          end
        end
        e.rise[m] = nq & ~mq[m];
        e.fall[m] = mq[m] & ~nq;
        mem[m] = clr ? conf : (mem[m] | conf);
        if (clr) mc[m] = (conf != 0) ? 1 : 0;
        else if (conf != 0 && mc[m] < 3) mc[m] = mc[m] + 1;
      end
      mq[m] = nq;
      e.q[m] = nq;
      e.qbar[m] = ~nq;
      e.errm[m] = mem[m];
      e.err[m] = |mem[m];
      e.cnt[m] = 2'(mc[m]);
    end
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents a new result after every rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int m = 0; m < 4; m++) begin
          chk("Q", m, w_q[m], e.q[m]);
          chk("Qbar", m, w_qbar[m], e.qbar[m]);
          chk("rise", m, w_rise[m], e.rise[m]);
          chk("fall", m, w_fall[m], e.fall[m]);
          chk("err_mask", m, w_errm[m], e.errm[m]);
          chk("err", m, {3'b000, w_err[m]}, {3'b000, e.err[m]});
          chk("conflict_cnt", m, {2'b00, w_cnt[m]}, {2'b00, e.cnt[m]});
        end
      end
    end
  end

  initial begin
    int k;
    for (int m = 0; m < 4; m++) begin
      mq[m] = RV; mem[m] = '0; mc[m] = 0;
    end
    // Directed sequences
    apply(1, 1, 4'b1111, 4'b0000, 1);
    apply(1, 0, 4'b0000, 4'b0000, 0);
    apply(0, 1, 4'b0001, 4'b0000, 0);
    apply(0, 1, 4'b0000, 4'b0000, 0);
    apply(0, 1, 4'b0000, 4'b0001, 0);
    apply(0, 1, 4'b0000, 4'b0000, 0);
    repeat (3) apply(0, 1, 4'b0100, 4'b0100, 0);
    apply(1, 0, 4'b0000, 4'b0000, 0);
    repeat (5) apply(0, 1, 4'b1111, 4'b1111, 0);
    apply(0, 1, 4'b0001, 4'b0001, 1);
    apply(0, 1, 4'b0010, 4'b0010, 0);
    apply(0, 0, 4'b1111, 4'b1111, 1);
    apply(0, 1, 4'b1111, 4'b0000, 0);
    apply(0, 1, 4'b1111, 4'b0000, 0);
    apply(1, 1, 4'b1111, 4'b0000, 0);
    apply(0, 0, 4'b0000, 4'b0000, 0);
    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      apply($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
            4'($urandom), 4'($urandom), $urandom_range(0, 9) == 0);
    end
    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
